// File: rtl/draw_caption_if.sv
`default_nettype none
// ============================================================================
// draw_caption_if : VGA timing bus plus pixel colour, one pixel per clock
// Revision 1.0
// ============================================================================
interface draw_caption_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface
`default_nettype wire

// File: rtl/draw_caption.sv
`default_nettype none
// ============================================================================
// draw_caption : caption-ROM addressing and compositing with frame-synchronous
//                enable and blinking; two-cycle pixel pipeline
// Revision 1.0
// ============================================================================
module draw_caption #(
    parameter int          XPOS         = 340,
    parameter int          YPOS         = 352,
    parameter int          WIDTH        = 344,
    parameter int          HEIGHT       = 64,
    parameter logic [11:0] COLOR        = 12'hF00,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    draw_caption_if.slave  vga_in,
    input  logic           pixel_bit,
    output logic [14:0]    address,
    draw_caption_if.master vga_out
);
    localparam logic [10:0] c_X_LO = 11'(XPOS);
    localparam logic [10:0] c_X_HI = 11'(XPOS + WIDTH - 1);
    localparam logic [10:0] c_Y_LO = 11'(YPOS);
    localparam logic [10:0] c_Y_HI = 11'(YPOS + HEIGHT - 1);
    localparam int          c_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

    logic               r_vblnk_prev;
    logic               r_en_q;
    logic               r_shown;
    logic [c_CNT_W-1:0] r_blink_cnt;
    logic               w_frame_start;

    logic               w_in_box;
    logic [21:0]        w_dx;
    logic [21:0]        w_dy;
    logic [21:0]        w_addr_full;

    logic [10:0]        r_s1_hcount;
    logic [10:0]        r_s1_vcount;
    logic               r_s1_hsync;
    logic               r_s1_vsync;
    logic               r_s1_hblnk;
    logic               r_s1_vblnk;
    logic [11:0]        r_s1_rgb;
    logic               r_s1_in_box;

    assign w_frame_start = vga_in.vblnk & ~r_vblnk_prev;

    // The frame start that first latches enable only opens the first half-period;
    // counting starts at the following frame start so the caption shows N full frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vblnk_prev <= 1'b0;
            r_en_q       <= 1'b0;
            r_shown      <= 1'b1;
            r_blink_cnt  <= '0;
        end else begin
            r_vblnk_prev <= vga_in.vblnk;
            if (w_frame_start) begin
                r_en_q <= enable;
                if (!enable) begin
                    r_blink_cnt <= '0;
                    r_shown     <= 1'b1;
                end else if ((BLINK_FRAMES != 0) && r_en_q) begin
                    if (r_blink_cnt == c_CNT_LAST) begin
                        r_blink_cnt <= '0;
                        r_shown     <= ~r_shown;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign w_in_box = (vga_in.hcount >= c_X_LO) && (vga_in.hcount <= c_X_HI) &&
                      (vga_in.vcount >= c_Y_LO) && (vga_in.vcount <= c_Y_HI);
    assign w_dx        = 22'(vga_in.hcount - c_X_LO);
    assign w_dy        = 22'(vga_in.vcount - c_Y_LO);
    assign w_addr_full = (w_dy * 22'(WIDTH)) + w_dx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            address     <= '0;
            r_s1_hcount <= '0;
            r_s1_vcount <= '0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_rgb    <= '0;
            r_s1_in_box <= 1'b0;
        end else begin
            address     <= w_in_box ? w_addr_full[14:0] : 15'd0;
            r_s1_hcount <= vga_in.hcount;
            r_s1_vcount <= vga_in.vcount;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s1_rgb    <= vga_in.rgb;
            r_s1_in_box <= w_in_box;
        end
    end

    // pixel_bit here belongs to the address issued one cycle earlier, i.e. to stage 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= r_s1_hcount;
            vga_out.vcount <= r_s1_vcount;
            vga_out.hsync  <= r_s1_hsync;
            vga_out.vsync  <= r_s1_vsync;
            vga_out.hblnk  <= r_s1_hblnk;
            vga_out.vblnk  <= r_s1_vblnk;
            if (r_s1_hblnk || r_s1_vblnk) begin
                vga_out.rgb <= 12'h000;
            end else if (r_s1_in_box && r_en_q && r_shown && pixel_bit) begin
                vga_out.rgb <= COLOR;
            end else begin
                vga_out.rgb <= r_s1_rgb;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_draw_caption.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_draw_caption : randomized scoreboard bench, blinking and non-blinking DUTs
// Revision 1.0
// ============================================================================
module tb_draw_caption;
    localparam int          XPOS   = 340;
    localparam int          YPOS   = 352;
    localparam int          WIDTH  = 344;
    localparam int          HEIGHT = 64;
    localparam logic [11:0] COLOR  = 12'hF00;
    localparam int          BLINK  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [14:0] address0;
    logic [14:0] address1;
    logic        pixel_bit0;
    logic        pixel_bit1;

    draw_caption_if vin();
    draw_caption_if vout0();
    draw_caption_if vout1();

    always #5 clk = ~clk;

    draw_caption #(.XPOS(XPOS), .YPOS(YPOS), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
                   .COLOR(COLOR), .BLINK_FRAMES(BLINK)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vga_in(vin),
        .pixel_bit(pixel_bit0), .address(address0), .vga_out(vout0));

    draw_caption #(.XPOS(XPOS), .YPOS(YPOS), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
                   .COLOR(COLOR), .BLINK_FRAMES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vga_in(vin),
        .pixel_bit(pixel_bit1), .address(address1), .vga_out(vout1));

    // Asynchronous-read ROM: data belongs to the address presented this cycle
    function automatic logic rom_bit(input logic [14:0] a);
        if (a == 15'd5) return 1'b1;
        if (a == 15'd4 || a == 15'd6) return 1'b0;
        return ^(a & 15'h2C9);
    endfunction
    assign pixel_bit0 = rom_bit(address0);
    assign pixel_bit1 = rom_bit(address1);

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } stim_t;

    typedef struct packed {
        logic [14:0] addr;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb0;
        logic [11:0] rgb1;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad = 0;

    stim_t prv;
    logic  m_en;
    int    m_k;
    logic  m_vprev;

    function automatic bit in_box(input int hc, input int vc);
        return hc >= XPOS && hc < XPOS + WIDTH && vc >= YPOS && vc < YPOS + HEIGHT;
    endfunction

    function automatic int addr_of(input int hc, input int vc);
        return in_box(hc, vc) ? (vc - YPOS) * WIDTH + (hc - XPOS) : 0;
    endfunction

    function automatic stim_t pix(input int hc, input int vc, input logic en);
        stim_t s;
        s = '0;
        s.en  = en;
        s.hc  = 11'(hc);
        s.vc  = 11'(vc);
        s.hs  = 1'($urandom_range(0, 1));
        s.vs  = 1'($urandom_range(0, 1));
        s.rgb = 12'($urandom);
        return s;
    endfunction

    function automatic stim_t pix_rand(input logic en);
        stim_t s;
        s = pix($urandom_range(XPOS - 4, XPOS + WIDTH + 3),
                $urandom_range(YPOS - 2, YPOS + HEIGHT + 1), en);
        s.hb = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    function automatic stim_t vbl(input logic en);
        stim_t s;
        s = pix($urandom_range(0, 2047), $urandom_range(0, 2047), en);
        s.hb = 1'($urandom_range(0, 1));
        s.vb = 1'b1;
        return s;
    endfunction

    // Drive one pixel and queue the output the DUTs must show at the next edge
    task automatic step(input stim_t s);
        exp_t e;
        bit   hit;
        @(negedge clk);
        rst_n       = ~s.rst;
        enable      = s.en;
        vin.hcount  = s.hc;
        vin.vcount  = s.vc;
        vin.hsync   = s.hs;
        vin.vsync   = s.vs;
        vin.hblnk   = s.hb;
        vin.vblnk   = s.vb;
        vin.rgb     = s.rgb;

        e = '0;
        if (!s.rst && !prv.rst) begin
            e.hc = prv.hc; e.vc = prv.vc;
            e.hs = prv.hs; e.vs = prv.vs; e.hb = prv.hb; e.vb = prv.vb;
            if (prv.hb || prv.vb) begin
                e.rgb0 = 12'h000;
                e.rgb1 = 12'h000;
            end else begin
                hit = in_box(int'(prv.hc), int'(prv.vc)) &&
                      rom_bit(15'(addr_of(int'(prv.hc), int'(prv.vc))));
                e.rgb0 = (hit && m_en && ((m_k / BLINK) % 2 == 0)) ? COLOR : prv.rgb;
                e.rgb1 = (hit && m_en) ? COLOR : prv.rgb;
            end
        end
        e.addr = s.rst ? 15'd0 : 15'(addr_of(int'(s.hc), int'(s.vc)));
        sb.push_back(e);

        // m_k counts frame starts since the one that turned the caption on
        if (s.rst) begin
            m_en = 1'b0; m_k = 0; m_vprev = 1'b0;
        end else begin
            if (s.vb && !m_vprev) begin
                if (!s.en) begin
                    m_en = 1'b0;
                end else if (!m_en) begin
                    m_en = 1'b1; m_k = 0;
                end else begin
                    m_k++;
                end
            end
            m_vprev = s.vb;
        end
        prv = s;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("address0", 32'(address0), 32'(e.addr));
                check("address1", 32'(address1), 32'(e.addr));
                check("timing0",
                      32'({vout0.hcount, vout0.vcount, vout0.hsync, vout0.vsync, vout0.hblnk, vout0.vblnk}),
                      32'({e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}));
                check("timing1",
                      32'({vout1.hcount, vout1.vcount, vout1.hsync, vout1.vsync, vout1.hblnk, vout1.vblnk}),
                      32'({e.hc, e.vc, e.hs, e.vs, e.hb, e.vb}));
                check("rgb_blink", 32'(vout0.rgb), 32'(e.rgb0));
                check("rgb_noblink", 32'(vout1.rgb), 32'(e.rgb1));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        logic  en_frame;
        prv = '0; prv.rst = 1'b1;
        m_en = 1'b0; m_k = 0; m_vprev = 1'b0;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

        repeat (3) begin
            s = pix_rand(1'($urandom_range(0, 1)));
            s.vb = 1'($urandom_range(0, 1));
            s.rst = 1'b1;
            step(s);
        end
        step(pix(XPOS, YPOS, 1'b1));

        // Enabling frame start, then the boundary and compositing points
        step(vbl(1'b1));
        step(vbl(1'b1));
        step(pix(340, 352, 1'b1));
        step(pix(683, 415, 1'b1));
        step(pix(684, 352, 1'b1));
        step(pix(339, 352, 1'b1));
        step(pix(345, 352, 1'b1));
        step(pix(344, 352, 1'b1));
        step(pix(346, 352, 1'b1));
        s = pix(345, 352, 1'b1); s.hb = 1'b1; step(s);
        step(pix(345, 352, 1'b1));

        // Enable raised mid-frame is ignored; dropped mid-frame is ignored too
        step(vbl(1'b0));
        step(vbl(1'b0));
        step(pix(345, 352, 1'b0));
        step(pix(345, 352, 1'b1));
        step(pix(345, 352, 1'b1));
        step(vbl(1'b1));
        step(pix(345, 352, 1'b1));
        step(pix(345, 352, 1'b0));
        step(pix(340, 352, 1'b0));

        for (int f = 0; f < 14; f++) begin
            en_frame = (f < 9) ? 1'b1 : 1'($urandom_range(0, 1));
            if (f == 12) en_frame = 1'b1;
            repeat (3) step(vbl(en_frame));
            step(pix(345, 352, en_frame));
            for (int p = 0; p < 60; p++) begin
                s = pix_rand(en_frame);
                if (f >= 9 && p >= 30) s.en = ~en_frame;
                if (f == 12 && p == 40) s.rst = 1'b1;
                step(s);
            end
        end

        repeat (2) step(pix_rand(1'b0));
        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
